// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_ctrl_pkg : shared encodings and defaults for the PWM sequencer |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package pwm_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam int DEF_CLK_FREQ    = 50_000_000;
  localparam int DEF_COUNTER_W   = 12;
  localparam int DEF_STEP_DIV    = 5000;
  localparam int DEF_RAMP_STEP   = 16;
  localparam int DEF_DEAD_CYCLES = 50_000;

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_ramp_tick : STEP_DIV prescaler producing a one-cycle ramp tick |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module pwm_ramp_tick
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick fires STEP_DIV cycles after the last clear.
  assign tick = !clear && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_ramp_controller : slew-limited speed/direction sequencer with  |
// |                       dead-time reversal and latched e-stop        |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int COUNTER_W   = DEF_COUNTER_W,
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int RAMP_STEP   = DEF_RAMP_STEP,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_enable,
  input  logic [COUNTER_W-1:0] cmd_duty,
  input  logic                 cmd_dir,
  input  logic                 estop,
  output logic                 enable,
  output logic [COUNTER_W-1:0] duty_cycle,
  output logic                 direction,
  output logic                 at_target,
  output logic                 fault
);

  localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [COUNTER_W:0] STEP_X   = (COUNTER_W + 1)'(RAMP_STEP);

  if (CLK_FREQ < 1 || STEP_DIV < 1 || RAMP_STEP < 1 || DEAD_CYCLES < 1 ||
      RAMP_STEP >= (1 << COUNTER_W)) begin : g_param_check
    $error("pwm_ramp_controller: illegal parameter set");
  end

  logic [1:0]           state_q, state_d;
  logic [COUNTER_W-1:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d;
  logic                 dir_q, dir_d, tgt_dir_q, tgt_dir_d, tgt_en_q, tgt_en_d;
  logic                 fault_q, fault_d, en_q, at_target_q, cmd_ready_q;
  logic [DEAD_W-1:0]    dead_cnt_q, dead_cnt_d;

  logic                 w_acc, w_load, w_tick, w_prescale_clr, w_up;
  logic                 w_tgt_dir, w_tgt_en;
  logic [COUNTER_W-1:0] w_cmd_duty, w_tgt_duty, w_next_duty;
  logic [COUNTER_W:0]   w_duty_x, w_tgt_x, w_diff, w_step, w_sum;

  assign w_acc      = cmd_valid && cmd_ready_q;
  assign w_load     = w_acc && !estop && !fault_q;
  assign w_cmd_duty = cmd_enable ? cmd_duty : '0;
  assign w_tgt_duty = w_load ? w_cmd_duty : tgt_duty_q;
  assign w_tgt_dir  = w_load ? cmd_dir    : tgt_dir_q;
  assign w_tgt_en   = w_load ? cmd_enable : tgt_en_q;

  // Prescaler only free-runs while the output is live on a ramp grid.
  assign w_prescale_clr = (state_q == ST_IDLE) || (state_q == ST_DEAD);

  pwm_ramp_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_prescale_clr),
    .tick  (w_tick)
  );

  // One slew step; a pending reversal always heads for zero first.
  always_comb begin
    w_duty_x = {1'b0, duty_q};
    w_tgt_x  = {1'b0, w_tgt_duty};
    w_up     = 1'b0;
    if (dir_q != w_tgt_dir) begin
      w_diff = w_duty_x;
    end else if (w_tgt_x > w_duty_x) begin
      w_diff = w_tgt_x - w_duty_x;
      w_up   = 1'b1;
    end else begin
      w_diff = w_duty_x - w_tgt_x;
    end
    w_step      = (w_diff < STEP_X) ? w_diff : STEP_X;
    w_sum       = w_up ? (w_duty_x + w_step) : (w_duty_x - w_step);
    w_next_duty = w_sum[COUNTER_W] ? '1 : w_sum[COUNTER_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    tgt_duty_d = w_tgt_duty;
    tgt_dir_d  = w_tgt_dir;
    tgt_en_d   = w_tgt_en;
    fault_d    = fault_q;
    dead_cnt_d = dead_cnt_q;
    if (estop) begin
      state_d    = ST_IDLE;
      duty_d     = '0;
      tgt_duty_d = '0;
      tgt_dir_d  = DIR_CW;
      tgt_en_d   = 1'b0;
      fault_d    = 1'b1;
    end else if (fault_q) begin
      if (w_acc && !cmd_enable) begin
        fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (w_acc && cmd_enable) begin
            dir_d   = cmd_dir;
            state_d = ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (w_tick) begin
            duty_d = w_next_duty;
          end
          if (dir_q != w_tgt_dir) begin
            if (duty_d == '0) begin
              state_d    = ST_DEAD;
              dead_cnt_d = '0;
            end
          end else if (duty_d == w_tgt_duty) begin
            state_d = w_tgt_en ? ST_HOLD : ST_IDLE;
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          if (dead_cnt_q == DEAD_LAST) begin
            dir_d   = ~dir_q;
            state_d = ST_RAMP;
          end else begin
            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_load && ((w_cmd_duty != duty_q) || (cmd_dir != dir_q) || !cmd_enable)) begin
            state_d = ST_RAMP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      dir_q       <= DIR_CW;
      tgt_duty_q  <= '0;
      tgt_dir_q   <= DIR_CW;
      tgt_en_q    <= 1'b0;
      fault_q     <= 1'b0;
      dead_cnt_q  <= '0;
      en_q        <= 1'b0;
      at_target_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      tgt_duty_q  <= tgt_duty_d;
      tgt_dir_q   <= tgt_dir_d;
      tgt_en_q    <= tgt_en_d;
      fault_q     <= fault_d;
      dead_cnt_q  <= dead_cnt_d;
      en_q        <= (state_d != ST_IDLE);
      at_target_q <= (state_d == ST_HOLD);
      cmd_ready_q <= (state_d != ST_DEAD);
    end
  end

  assign enable     = en_q;
  assign duty_cycle = duty_q;
  assign direction  = dir_q;
  assign at_target  = at_target_q;
  assign fault      = fault_q;
  assign cmd_ready  = cmd_ready_q;

endmodule
`default_nettype wire
